// File: rtl/comporta_pkg.sv
// Shared definitions for the gate servo path: position width, PWM FSM
// encodings and the default 50 MHz timing constants.
package comporta_pkg;

    localparam int POS_W                = 3;
    localparam int PERIODO_PADRAO       = 1_000_000;
    localparam int LARGURA_MIN_PADRAO   = 50_000;
    localparam int LARGURA_PASSO_PADRAO = 7_142;
    localparam int POSICOES_PADRAO      = 8;

    typedef enum logic [1:0] {
        DESLIGADO = 2'd0,
        ALTO      = 2'd1,
        BAIXO     = 2'd2
    } estado_t;

    // Debug code for the state register; any unlisted encoding reads as F.
    function automatic logic [3:0] db_codigo(input estado_t estado);
        logic [3:0] codigo;
        case (estado)
            DESLIGADO: codigo = 4'h0;
            ALTO:      codigo = 4'h1;
            BAIXO:     codigo = 4'h2;
            default:   codigo = 4'hF;
        endcase
        return codigo;
    endfunction

endpackage

// File: rtl/comporta_pwm_contador_periodo.sv
// Period counter for the servo PWM: synchronous clear has priority over
// enable, terminal flags the last clock of a period.
module contador_periodo
    import comporta_pkg::*;
#(
    parameter int PERIODO = PERIODO_PADRAO,
    parameter int CONT_W  = $clog2(PERIODO)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              limpar,
    input  logic              habilitar,
    output logic [CONT_W-1:0] cont,
    output logic              terminal
);

    logic [CONT_W-1:0] cont_q;
    logic [CONT_W-1:0] cont_d;

    // Next count value
    always_comb begin
        cont_d = cont_q;
        if (limpar) begin
            cont_d = {CONT_W{1'b0}};
        end else if (habilitar) begin
            cont_d = cont_q + {{(CONT_W-1){1'b0}}, 1'b1};
        end else begin
            cont_d = cont_q;
        end
    end

    // Count register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cont_q <= {CONT_W{1'b0}};
        end else begin
            cont_q <= cont_d;
        end
    end

    assign cont     = cont_q;
    assign terminal = (cont_q == CONT_W'(PERIODO - 1));

endmodule

// File: rtl/comporta_pwm.sv
// Gate servo PWM stage: fixed-period pulse whose width follows the position
// latched at each period boundary, so a live position change never glitches.
module comporta_pwm
    import comporta_pkg::*;
#(
    parameter int PERIODO       = PERIODO_PADRAO,
    parameter int LARGURA_MIN   = LARGURA_MIN_PADRAO,
    parameter int LARGURA_PASSO = LARGURA_PASSO_PADRAO,
    parameter int POSICOES      = POSICOES_PADRAO
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ligar,
    input  logic [POS_W-1:0] posicao,
    output logic             pwm,
    output logic             fimPeriodo,
    output logic [POS_W-1:0] posicaoAplicada,
    output logic [3:0]       dbEstado
);

    localparam int CONT_W = $clog2(PERIODO);
    localparam logic [POS_W:0] POS_LIMITE = (POS_W + 1)'(POSICOES);
    localparam logic [POS_W:0] POS_MAX    = (POS_W + 1)'(POSICOES - 1);

    estado_t           estado_q;
    estado_t           estado_d;
    logic              pwm_q;
    logic              pwm_d;
    logic [POS_W-1:0]  posicao_aplicada_q;
    logic [POS_W-1:0]  posicao_aplicada_d;
    logic [POS_W-1:0]  posicao_sat_s;
    logic [CONT_W-1:0] cont_s;
    logic [CONT_W-1:0] largura_s;
    logic              terminal_s;
    logic              limpar_s;
    logic              habilitar_s;
    logic              capturar_s;
    logic              fim_s;

    contador_periodo #(
        .PERIODO (PERIODO),
        .CONT_W  (CONT_W)
    ) u_contador (
        .clock     (clock),
        .reset     (reset),
        .limpar    (limpar_s),
        .habilitar (habilitar_s),
        .cont      (cont_s),
        .terminal  (terminal_s)
    );

    assign posicao_sat_s = ({1'b0, posicao} >= POS_LIMITE) ? POS_MAX[POS_W-1:0] : posicao;

    // Width comes only from the latched position, never from the live input.
    assign largura_s = CONT_W'(LARGURA_MIN)
                     + CONT_W'(LARGURA_PASSO) * CONT_W'(posicao_aplicada_q);

    // Next-state, pwm and counter control
    always_comb begin
        estado_d    = estado_q;
        pwm_d       = pwm_q;
        limpar_s    = 1'b0;
        habilitar_s = 1'b0;
        capturar_s  = 1'b0;
        fim_s       = 1'b0;
        case (estado_q)
            DESLIGADO: begin
                limpar_s = 1'b1;
                pwm_d    = 1'b0;
                if (ligar) begin
                    estado_d   = ALTO;
                    pwm_d      = 1'b1;
                    capturar_s = 1'b1;
                end else begin
                    estado_d   = DESLIGADO;
                end
            end
            ALTO: begin
                habilitar_s = 1'b1;
                pwm_d       = 1'b1;
                if (cont_s == largura_s - {{(CONT_W-1){1'b0}}, 1'b1}) begin
                    estado_d = BAIXO;
                    pwm_d    = 1'b0;
                end else begin
                    estado_d = ALTO;
                end
            end
            BAIXO: begin
                habilitar_s = 1'b1;
                pwm_d       = 1'b0;
                if (terminal_s) begin
                    fim_s    = 1'b1;
                    limpar_s = 1'b1;
                    // Restarting straight into ALTO keeps periods back to back.
                    if (ligar) begin
                        estado_d   = ALTO;
                        pwm_d      = 1'b1;
                        capturar_s = 1'b1;
                    end else begin
                        estado_d   = DESLIGADO;
                    end
                end else begin
                    estado_d = BAIXO;
                end
            end
            default: begin
                estado_d = DESLIGADO;
                pwm_d    = 1'b0;
                limpar_s = 1'b1;
            end
        endcase
    end

    // Position capture on every entry into ALTO
    always_comb begin
        if (capturar_s) begin
            posicao_aplicada_d = posicao_sat_s;
        end else begin
            posicao_aplicada_d = posicao_aplicada_q;
        end
    end

    // State, pwm and captured-position registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q           <= DESLIGADO;
            pwm_q              <= 1'b0;
            posicao_aplicada_q <= {POS_W{1'b0}};
        end else begin
            estado_q           <= estado_d;
            pwm_q              <= pwm_d;
            posicao_aplicada_q <= posicao_aplicada_d;
        end
    end

    assign pwm             = pwm_q;
    assign fimPeriodo      = fim_s;
    assign posicaoAplicada = posicao_aplicada_q;
    assign dbEstado        = db_codigo(estado_q);

endmodule
